// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port sharing bus: writeback port A, buffered aux port B,
// and the arbitrated write port plus hazard/stall status.
interface regfile_wr_arbiter_if #(
  parameter int SIZE       = 32,
  parameter int AMOUNT_REG = 4,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Port A: never back-pressured, a_we qualifies a_ra/a_wd in the same cycle.
  logic                     a_we;
  logic [AMOUNT_REG-1:0]    a_ra;
  logic [SIZE-1:0]          a_wd;
  // Port B handshake: a transfer happens on the rising edge where b_valid and
  // b_ready are both high; b_ra/b_wd must be stable while b_valid is high, and
  // b_ready depends only on registered occupancy, never on b_valid.
  logic                     b_valid;
  logic                     b_ready;
  logic [AMOUNT_REG-1:0]    b_ra;
  logic [SIZE-1:0]          b_wd;
  logic                     we3;
  logic [AMOUNT_REG-1:0]    ra3;
  logic [SIZE-1:0]          wd3;
  logic                     stall;
  logic [2**AMOUNT_REG-1:0] pend_mask;
  logic                     b_drop;
  logic [CNT_W-1:0]         count;

  modport master (
    output a_we, a_ra, a_wd, b_valid, b_ra, b_wd,
    input  b_ready, we3, ra3, wd3, stall, pend_mask, b_drop, count
  );

  modport slave (
    input  a_we, a_ra, a_wd, b_valid, b_ra, b_wd,
    output b_ready, we3, ra3, wd3, stall, pend_mask, b_drop, count
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the writeback stage
// (absolute priority) and a FIFO-buffered auxiliary writer.
module regfile_wr_arbiter #(
  parameter int SIZE       = 32,
  parameter int AMOUNT_REG = 4,
  parameter int DEPTH      = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int NREG   = 2 ** AMOUNT_REG;
  localparam logic [AMOUNT_REG-1:0] PC_REG = AMOUNT_REG'(15);

  logic [AMOUNT_REG-1:0] q_ra [DEPTH];
  logic [SIZE-1:0]       q_wd [DEPTH];
  logic [DEPTH-1:0]      q_live;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count_r;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  drop_r;

  logic                  not_empty;
  logic                  ready;
  logic                  push;
  logic                  is_pc;
  logic                  enq;
  logic                  pop;
  logic                  we_c;
  logic [AMOUNT_REG-1:0] ra_c;
  logic [SIZE-1:0]       wd_c;
  logic [NREG-1:0]       mask_c;

  assign not_empty = (count_r != '0);
  assign ready     = (count_r != CNT_W'(DEPTH));
  assign push      = bus.b_valid && ready;
  assign is_pc     = (bus.b_ra == PC_REG);
  assign enq       = push && !is_pc;
  assign pop       = !bus.a_we && not_empty;

  // A killed head still pops (consuming the slot) but drives no write.
  always_comb begin
    we_c = 1'b0;
    ra_c = '0;
    wd_c = '0;
    if (!rst) begin
      if (bus.a_we) begin
        we_c = 1'b1;
        ra_c = bus.a_ra;
        wd_c = bus.a_wd;
      end else if (not_empty && q_live[rd_ptr]) begin
        we_c = 1'b1;
        ra_c = q_ra[rd_ptr];
        wd_c = q_wd[rd_ptr];
      end
    end
  end

  always_comb begin
    mask_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i]) mask_c[q_ra[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_ra[wr_ptr] <= bus.b_ra;
      q_wd[wr_ptr] <= bus.b_wd;
    end
  end

  // Live bits are cleared on pop so they only ever describe occupied slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_live   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_r  <= '0;
      wait_cnt <= '0;
      drop_r   <= 1'b0;
    end else begin
      if (bus.a_we) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_live[i] && (q_ra[i] == bus.a_ra)) q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      // The slot written here is free, so the kill above never touches it.
      if (enq) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if (!not_empty || pop) begin
        wait_cnt <= '0;
      end else if (bus.a_we && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      drop_r <= push && is_pc;
    end
  end

  assign bus.b_ready   = ready;
  assign bus.we3       = we_c;
  assign bus.ra3       = ra_c;
  assign bus.wd3       = wd_c;
  assign bus.stall     = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign bus.pend_mask = mask_c;
  assign bus.b_drop    = drop_r;
  assign bus.count     = count_r;
endmodule
